// File: rtl/ps2_mouse_cursor_pkg.sv
// Shared types and constants for the PS/2 mouse cursor tracker.
// Holds the FSM encoding, byte1 bit positions and the captured-packet layout.
package ps2_mouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_CALC,
    ST_CLAMP,
    ST_PUBLISH
  } state_t;

  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_M   = 2;
  localparam int ALWAYS1 = 3;
  localparam int XSIGN   = 4;
  localparam int YSIGN   = 5;
  localparam int XOVF    = 6;
  localparam int YOVF    = 7;

  localparam int DELTA_W = 9;
  // Wide enough for a 10-bit position plus a 9-bit delta shifted by up to 3.
  localparam int SUM_W   = 13;

  // Only the byte1 fields used after validation are kept.
  typedef struct packed {
    logic       yovf;
    logic       xovf;
    logic       ysign;
    logic       xsign;
    logic [2:0] btn;
    logic [7:0] x_mag;
    logic [7:0] y_mag;
  } motion_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_mouse_cursor_if.sv
// Packet-in / cursor-out bundle between the packet assembler, this tracker and UI logic.
// master drives packets and recenter; slave is the cursor tracker.
interface ps2_mouse_cursor_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic [7:0]     byte1;
  logic [7:0]     byte2;
  logic [7:0]     byte3;
  logic           packet_ready;
  logic           recenter;
  logic [X_W-1:0] cursor_x;
  logic [Y_W-1:0] cursor_y;
  logic [2:0]     buttons;
  logic           cursor_update;
  logic           packet_error;
  logic [7:0]     drop_count;

  modport master (
    output byte1, byte2, byte3, packet_ready, recenter,
    input  cursor_x, cursor_y, buttons, cursor_update, packet_error, drop_count
  );

  modport slave (
    input  byte1, byte2, byte3, packet_ready, recenter,
    output cursor_x, cursor_y, buttons, cursor_update, packet_error, drop_count
  );
endinterface

// File: rtl/ps2_axis_clamp.sv
// One cursor axis: sign-extends and scales a PS/2 delta, applies it to the current
// position (registered in CALC) and clamps the registered sum to 0..EXTENT-1.
module ps2_axis_clamp
  import ps2_mouse_pkg::*;
#(
  parameter int EXTENT      = 640,
  parameter int WIDTH       = 10,
  parameter bit INVERT      = 1'b0,
  parameter int SCALE_SHIFT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             calc_en,
  input  logic [WIDTH-1:0] pos,
  input  logic             sign,
  input  logic [7:0]       mag,
  input  logic             ovf,
  output logic [WIDTH-1:0] clamped
);

  localparam logic signed [SUM_W-1:0] MAX_SUM = SUM_W'(EXTENT - 1);
  localparam logic        [WIDTH-1:0] MAX_OUT = WIDTH'(EXTENT - 1);

  logic signed [DELTA_W-1:0] delta9;
  logic signed [SUM_W-1:0]   delta;
  logic signed [SUM_W-1:0]   pos_ext;
  logic signed [SUM_W-1:0]   sum_next;
  logic signed [SUM_W-1:0]   sum_q;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    delta9   = ovf ? '0 : {sign, mag};
    delta    = {{(SUM_W-DELTA_W){delta9[DELTA_W-1]}}, delta9} <<< SCALE_SHIFT;
    pos_ext  = {{(SUM_W-WIDTH){1'b0}}, pos};
    // Inverted axis turns PS/2 up-positive into screen down-positive.
    sum_next = INVERT ? (pos_ext - delta) : (pos_ext + delta);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (calc_en) begin
      sum_q <= sum_next;
    end
  end

  always_comb begin
    if (sum_q[SUM_W-1]) begin
      clamped = '0;
    end else if (sum_q > MAX_SUM) begin
      clamped = MAX_OUT;
    end else begin
      clamped = sum_q[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ps2_mouse_cursor.sv
// Turns validated three-byte PS/2 mouse packets into an absolute, screen-clamped
// cursor position and button state, with recenter and busy-drop accounting.
module ps2_mouse_cursor
  import ps2_mouse_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int SCALE_SHIFT = 0
) (
  input logic               clk,
  input logic               reset,
  ps2_mouse_cursor_if.slave bus
);

  localparam logic [X_W-1:0] X_CENTER = X_W'(SCREEN_W / 2);
  localparam logic [Y_W-1:0] Y_CENTER = Y_W'(SCREEN_H / 2);

  logic       sync1, sync2, sync3;
  logic [1:0] prime_cnt;
  logic       ready_edge;

  state_t  state, state_next;
  logic    capture_en, calc_en, publish_en, error_set, drop_inc;
  motion_t pkt;

  logic [X_W-1:0] clamp_x, cur_x;
  logic [Y_W-1:0] clamp_y, cur_y;
  logic [2:0]     btn;
  logic           update, error;
  logic [7:0]     drops;

  // Edge detect is held off until the history flop has taken a sample from after
  // reset, so a packet_ready already high at reset release is not seen as new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      prime_cnt <= 2'd0;
    end else begin
      sync1     <= bus.packet_ready;
      sync2     <= sync1;
      sync3     <= sync2;
      prime_cnt <= (prime_cnt == 2'd3) ? prime_cnt : prime_cnt + 2'd1;
    end
  end

  assign ready_edge = sync2 & ~sync3 & (prime_cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.recenter) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (ready_edge) state_next = ST_CAPTURE;
        ST_CAPTURE: state_next = bus.byte1[ALWAYS1] ? ST_CALC : ST_IDLE;
        ST_CALC:    state_next = ST_CLAMP;
        ST_CLAMP:   state_next = ST_PUBLISH;
        ST_PUBLISH: state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Recenter aborts whatever the FSM is doing, so every strobe is gated by it.
  always_comb begin
    capture_en = 1'b0;
    calc_en    = 1'b0;
    publish_en = 1'b0;
    error_set  = 1'b0;
    drop_inc   = ready_edge && (state != ST_IDLE) && !bus.recenter;
    if (!bus.recenter) begin
      unique case (state)
        ST_CAPTURE: begin
          capture_en = bus.byte1[ALWAYS1];
          error_set  = !bus.byte1[ALWAYS1];
        end
        ST_CALC:  calc_en    = 1'b1;
        ST_CLAMP: publish_en = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the capture register is reset even though it is always written before
  // use, so every flop has a defined value straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt <= '0;
    end else if (capture_en) begin
      pkt <= '{yovf:  bus.byte1[YOVF],  xovf:  bus.byte1[XOVF],
               ysign: bus.byte1[YSIGN], xsign: bus.byte1[XSIGN],
               btn:   bus.byte1[BTN_M:BTN_L],
               x_mag: bus.byte2,        y_mag: bus.byte3};
    end
  end

  ps2_axis_clamp #(
    .EXTENT(SCREEN_W), .WIDTH(X_W), .INVERT(1'b0), .SCALE_SHIFT(SCALE_SHIFT)
  ) u_clamp_x (
    .clk(clk), .reset(reset), .calc_en(calc_en), .pos(cur_x),
    .sign(pkt.xsign), .mag(pkt.x_mag), .ovf(pkt.xovf), .clamped(clamp_x)
  );

  ps2_axis_clamp #(
    .EXTENT(SCREEN_H), .WIDTH(Y_W), .INVERT(1'b1), .SCALE_SHIFT(SCALE_SHIFT)
  ) u_clamp_y (
    .clk(clk), .reset(reset), .calc_en(calc_en), .pos(cur_y),
    .sign(pkt.ysign), .mag(pkt.y_mag), .ovf(pkt.yovf), .clamped(clamp_y)
  );

  // Outputs are loaded as CLAMP ends, so they appear with cursor_update in PUBLISH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_x  <= X_CENTER;
      cur_y  <= Y_CENTER;
      btn    <= 3'b000;
      update <= 1'b0;
      error  <= 1'b0;
      drops  <= 8'd0;
    end else begin
      update <= bus.recenter | publish_en;
      error  <= error_set;
      if (bus.recenter) begin
        cur_x <= X_CENTER;
        cur_y <= Y_CENTER;
      end else if (publish_en) begin
        cur_x <= clamp_x;
        cur_y <= clamp_y;
        btn   <= pkt.btn;
      end
      if (drop_inc) drops <= sat_inc8(drops);
    end
  end

  assign bus.cursor_x      = cur_x;
  assign bus.cursor_y      = cur_y;
  assign bus.buttons       = btn;
  assign bus.cursor_update = update;
  assign bus.packet_error  = error;
  assign bus.drop_count    = drops;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Self-checking bench for ps2_mouse_cursor: directed scenarios plus random packets
// compared against an arithmetic model of cursor motion, clamping and timing.
module tb_ps2_mouse_cursor;

  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int XW    = 10;
  localparam int YW    = 9;
  localparam int SHIFT = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ps2_mouse_cursor_if #(.X_W(XW), .Y_W(YW)) bus();

  ps2_mouse_cursor #(
    .SCREEN_W(SW), .SCREEN_H(SH), .X_W(XW), .Y_W(YW), .SCALE_SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int mx, my, mbtn, mdrop;
  // Observations from the last packet window (cycle numbers count edges after drive)
  int first_upd, n_upd, first_err, n_err;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int axis(input int pos, input bit sign, input logic [7:0] mag,
                              input bit ovf, input bit invert, input int extent);
    int d, r;
    d = ovf ? 0 : (sign ? int'(mag) - 256 : int'(mag));
    d = d * (1 << SHIFT);
    r = invert ? pos - d : pos + d;
    if (r < 0) r = 0;
    if (r > extent - 1) r = extent - 1;
    return r;
  endfunction

  task automatic model_packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    if (b1[3]) begin
      mx   = axis(mx, b1[4], b2, b1[6], 1'b0, SW);
      my   = axis(my, b1[5], b3, b1[7], 1'b1, SH);
      mbtn = int'(b1[2:0]);
    end
  endtask

  task automatic model_reset();
    mx = SW / 2; my = SH / 2; mbtn = 0; mdrop = 0;
  endtask

  // Entered and left at posedge+1. reready_at>0: drop ready after edge 1 and
  // raise it again after that edge. rc_at>0: pulse recenter for one cycle.
  task automatic send(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                      input int reready_at, input int rc_at);
    bus.byte1 = b1; bus.byte2 = b2; bus.byte3 = b3;
    bus.packet_ready = 1'b1;
    first_upd = -1; n_upd = 0; first_err = -1; n_err = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.cursor_update) begin
        if (first_upd < 0) first_upd = c;
        n_upd++;
      end
      if (bus.packet_error) begin
        if (first_err < 0) first_err = c;
        n_err++;
      end
      if (reready_at > 0 && c == 1) bus.packet_ready = 1'b0;
      if (reready_at > 0 && c == reready_at) bus.packet_ready = 1'b1;
      bus.recenter = (c == rc_at);
    end
    bus.packet_ready = 1'b0;
    bus.recenter = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_x"},    int'(bus.cursor_x),   mx);
    check({tag, "_y"},    int'(bus.cursor_y),   my);
    check({tag, "_btn"},  int'(bus.buttons),    mbtn);
    check({tag, "_drop"}, int'(bus.drop_count), mdrop);
  endtask

  task automatic check_packet(input string tag, input logic [7:0] b1);
    if (b1[3]) begin
      check({tag, "_upd_lat"}, first_upd, 6);
      check({tag, "_upd_n"},   n_upd,     1);
      check({tag, "_err_n"},   n_err,     0);
    end else begin
      check({tag, "_err_lat"}, first_err, 4);
      check({tag, "_err_n"},   n_err,     1);
      check({tag, "_upd_n"},   n_upd,     0);
    end
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b1, b2, b3;
    bus.byte1 = 8'h00; bus.byte2 = 8'h00; bus.byte3 = 8'h00;
    bus.packet_ready = 1'b0; bus.recenter = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_x",   int'(bus.cursor_x),      320);
    check("rst_y",   int'(bus.cursor_y),      240);
    check("rst_btn", int'(bus.buttons),       0);
    check("rst_upd", int'(bus.cursor_update), 0);
    check("rst_err", int'(bus.packet_error),  0);
    check("rst_drp", int'(bus.drop_count),    0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Basic move: +10 right, +5 up
    send(8'h08, 8'h0A, 8'h05, -1, -1);
    model_packet(8'h08, 8'h0A, 8'h05);
    check_packet("basic", 8'h08);
    check("basic_x330", int'(bus.cursor_x), 330);
    check("basic_y235", int'(bus.cursor_y), 235);

    // Two -256 moves clamp at the left edge
    do_reset();
    send(8'h19, 8'h00, 8'h00, -1, -1);
    model_packet(8'h19, 8'h00, 8'h00);
    check_packet("neg1", 8'h19);
    send(8'h19, 8'h00, 8'h00, -1, -1);
    model_packet(8'h19, 8'h00, 8'h00);
    check_packet("neg2", 8'h19);
    check("neg_x0",   int'(bus.cursor_x), 0);
    check("neg_btn1", int'(bus.buttons),  1);

    // X overflow discards dx but still publishes
    do_reset();
    send(8'h48, 8'h7F, 8'h00, -1, -1);
    model_packet(8'h48, 8'h7F, 8'h00);
    check_packet("xovf", 8'h48);
    check("xovf_x320", int'(bus.cursor_x), 320);

    // Bit 3 clear rejects the packet
    send(8'h00, 8'h33, 8'h44, -1, -1);
    model_packet(8'h00, 8'h33, 8'h44);
    check_packet("bad", 8'h00);

    // Second rising edge while busy is dropped
    send(8'h08, 8'h10, 8'h00, 3, -1);
    model_packet(8'h08, 8'h10, 8'h00);
    mdrop = mdrop + 1;
    check_packet("drop", 8'h08);
    check("drop_cnt1", int'(bus.drop_count), 1);

    // Recenter during CALC aborts the packet and republishes the centre
    send(8'h0B, 8'h20, 8'h20, -1, 4);
    mx = SW / 2; my = SH / 2;
    check("rc_upd_lat", first_upd, 5);
    check("rc_upd_n",   n_upd,     1);
    check("rc_err_n",   n_err,     0);
    check_outputs("rc");

    // Random packets against the model
    for (int i = 0; i < 24; i++) begin
      b1 = 8'($urandom);
      b1[3] = ($urandom_range(0, 7) != 0);
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      send(b1, b2, b3, -1, -1);
      model_packet(b1, b2, b3);
      check_packet($sformatf("rnd%0d", i), b1);
    end

    // Reset mid-packet, released with packet_ready still high
    bus.byte1 = 8'h08; bus.byte2 = 8'h50; bus.byte3 = 8'h50;
    bus.packet_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("midrst");
    check("midrst_upd", int'(bus.cursor_update), 0);
    @(negedge clk) rst_n = 1'b1;
    n_upd = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.cursor_update) n_upd++;
    end
    check("held_ready_upd_n", n_upd, 0);
    check_outputs("held_ready");
    bus.packet_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Normal operation resumes
    send(8'h2C, 8'h05, 8'hF0, -1, -1);
    model_packet(8'h2C, 8'h05, 8'hF0);
    check_packet("resume", 8'h2C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
